// File: rtl/dm_arb_pkg.sv
// Shared DM op codes, FSM state encoding and op-class helpers for the DM arbiter.
package dm_arb_pkg;

  localparam logic [2:0] DM_LB        = 3'b000;
  localparam logic [2:0] DM_LBU       = 3'b001;
  localparam logic [2:0] DM_LH        = 3'b010;
  localparam logic [2:0] DM_LHU       = 3'b011;
  localparam logic [2:0] DM_LW        = 3'b100;
  localparam logic [2:0] DM_SB        = 3'b101;
  localparam logic [2:0] DM_SH        = 3'b110;
  localparam logic [2:0] DM_SW        = 3'b111;
  localparam logic [2:0] DM_IDLE_CTRL = DM_LB;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

  function automatic logic is_store(input logic [2:0] ctrl);
    return (ctrl == DM_SB) || (ctrl == DM_SH) || (ctrl == DM_SW);
  endfunction

endpackage

// File: rtl/dm_arbiter_if.sv
// One master's request/grant/completion bundle; optional lock bit under DM_ARB_LOCK_EN.
interface dm_arb_if;
  logic        req;
  logic [2:0]  ctrl;
  logic [31:0] addr;
  logic [31:0] wdata;
`ifdef DM_ARB_LOCK_EN
  logic        lock;
`endif
  logic        gnt;
  logic        done;
  logic        err;
  logic [31:0] rdata;

`ifdef DM_ARB_LOCK_EN
  modport master (output req, ctrl, addr, wdata, lock, input gnt, done, err, rdata);
  modport slave  (input req, ctrl, addr, wdata, lock, output gnt, done, err, rdata);
`else
  modport master (output req, ctrl, addr, wdata, input gnt, done, err, rdata);
  modport slave  (input req, ctrl, addr, wdata, output gnt, done, err, rdata);
`endif
endinterface

// File: rtl/dm_arb_chk.sv
// Combinational alignment/range check; substitutes the idle code so a bad access never reaches the DM.
module dm_arb_chk
  import dm_arb_pkg::*;
#(
  parameter int DM_WORDS = 2048
) (
  input  logic [2:0]  i_ctrl,
  input  logic [31:0] i_addr,
  output logic        o_misaligned,
  output logic        o_out_of_range,
  output logic [2:0]  o_ctrl_to_dm
);

  localparam logic [32:0] LIMIT = 33'(DM_WORDS) << 2;

  always_comb begin
    o_misaligned = 1'b0;
    case (i_ctrl)
      DM_LH, DM_LHU, DM_SH: o_misaligned = i_addr[0];
      DM_LW, DM_SW:         o_misaligned = |i_addr[1:0];
      default:              o_misaligned = 1'b0;
    endcase
  end

  assign o_out_of_range = ({1'b0, i_addr} >= LIMIT);
  assign o_ctrl_to_dm   = (o_misaligned || o_out_of_range) ? DM_IDLE_CTRL : i_ctrl;

endmodule

// File: rtl/dm_arbiter.sv
// Two-master DM arbiter: capture at end of T, grant+access in T+1, done in T+2; one access/cycle peak.
// Optional DM_ARB_LOCK_EN adds per-master lock for read-modify-write atomicity.
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter bit RR_EN    = 1'b1,
  parameter int DM_WORDS = 2048
) (
  input  logic        clk,
  input  logic        rst_n,
  dm_arb_if.slave     m0,
  dm_arb_if.slave     m1,
  output logic [2:0]  dm_ctrl,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wd,
  input  logic [31:0] dm_rd
);

  localparam logic [0:0] S_IDLE   = 1'(ST_IDLE);
  localparam logic [0:0] S_ACCESS = 1'(ST_ACCESS);

  logic [0:0]  r_state;
  logic        r_own;
  logic        r_ptr;
  logic [2:0]  r_ctrl;
  logic [31:0] r_addr;
  logic [31:0] r_wd;
  logic [1:0]  r_gnt;
  logic [1:0]  r_done;
  logic [1:0]  r_err;
  logic [31:0] r_rdata [2];

  logic [1:0]  w_blk;
  logic [1:0]  w_req;
  logic        w_any;
  logic        w_win;
  logic        w_lock_in;
  logic        w_freeze;
  logic        w_mis;
  logic        w_oor;
  logic        w_err;
  logic [2:0]  w_chk_ctrl;

`ifdef DM_ARB_LOCK_EN
  logic r_lock_vld;
  logic r_lock_own;

  assign w_blk     = {r_lock_vld & ~r_lock_own, r_lock_vld & r_lock_own};
  assign w_lock_in = w_win ? m1.lock : m0.lock;
  assign w_freeze  = r_lock_vld | w_lock_in;

  // Only the owner can win while locked, so any capture without lock releases it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock_vld <= 1'b0;
      r_lock_own <= 1'b0;
    end else if (w_any) begin
      r_lock_vld <= w_lock_in;
      if (w_lock_in) r_lock_own <= w_win;
    end
  end
`else
  assign w_blk     = 2'b00;
  assign w_lock_in = 1'b0;
  assign w_freeze  = 1'b0;
`endif

  // A master's req is ignored in its own grant cycle; that is what bounds it to one access per 2 cycles.
  assign w_req = {m1.req & ~r_gnt[1] & ~w_blk[1], m0.req & ~r_gnt[0] & ~w_blk[0]};
  assign w_any = |w_req;
  assign w_win = (w_req[0] & w_req[1]) ? (RR_EN ? r_ptr : 1'b0) : w_req[1];

  dm_arb_chk #(.DM_WORDS(DM_WORDS)) u_chk (
    .i_ctrl         (r_ctrl),
    .i_addr         (r_addr),
    .o_misaligned   (w_mis),
    .o_out_of_range (w_oor),
    .o_ctrl_to_dm   (w_chk_ctrl)
  );

  assign w_err   = w_mis | w_oor;
  assign dm_ctrl = (r_state == S_ACCESS) ? w_chk_ctrl : DM_IDLE_CTRL;
  assign dm_addr = r_addr;
  assign dm_wd   = r_wd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_own      <= 1'b0;
      r_ptr      <= 1'b0;
      r_ctrl     <= DM_IDLE_CTRL;
      r_addr     <= '0;
      r_wd       <= '0;
      r_gnt      <= '0;
      r_done     <= '0;
      r_err      <= '0;
      r_rdata[0] <= '0;
      r_rdata[1] <= '0;
    end else begin
      r_gnt  <= '0;
      r_done <= '0;
      r_err  <= '0;
      if (r_state == S_ACCESS) begin
        r_done[r_own] <= 1'b1;
        r_err[r_own]  <= w_err;
        if (!w_err && !is_store(r_ctrl)) r_rdata[r_own] <= dm_rd;
      end
      if (w_any) begin
        r_state      <= S_ACCESS;
        r_own        <= w_win;
        r_ctrl       <= w_win ? m1.ctrl  : m0.ctrl;
        r_addr       <= w_win ? m1.addr  : m0.addr;
        r_wd         <= w_win ? m1.wdata : m0.wdata;
        r_gnt[w_win] <= 1'b1;
        if (RR_EN && !w_freeze) r_ptr <= ~w_win;
      end else begin
        r_state <= S_IDLE;
      end
    end
  end

  assign m0.gnt   = r_gnt[0];
  assign m1.gnt   = r_gnt[1];
  assign m0.done  = r_done[0];
  assign m1.done  = r_done[1];
  assign m0.err   = r_err[0];
  assign m1.err   = r_err[1];
  assign m0.rdata = r_rdata[0];
  assign m1.rdata = r_rdata[1];

endmodule

// File: tb/tb_dm_arbiter.sv
// Scoreboard bench for dm_arbiter with a behavioural 2048x32 DM; lock scenario built when DM_ARB_LOCK_EN is defined.
module tb_dm_arbiter;
  import dm_arb_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req   [2];
  logic [2:0]  ctrl  [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic        lock  [2];
  logic        gnt   [2];
  logic        done  [2];
  logic        err   [2];
  logic [31:0] rdata [2];

  logic [2:0]  dm_ctrl;
  logic [31:0] dm_addr, dm_wd, dm_rd;

  dm_arb_if m0_if ();
  dm_arb_if m1_if ();

  assign m0_if.req = req[0];   assign m1_if.req = req[1];
  assign m0_if.ctrl = ctrl[0]; assign m1_if.ctrl = ctrl[1];
  assign m0_if.addr = addr[0]; assign m1_if.addr = addr[1];
  assign m0_if.wdata = wdata[0]; assign m1_if.wdata = wdata[1];
`ifdef DM_ARB_LOCK_EN
  assign m0_if.lock = lock[0]; assign m1_if.lock = lock[1];
`endif
  assign gnt[0] = m0_if.gnt;     assign gnt[1] = m1_if.gnt;
  assign done[0] = m0_if.done;   assign done[1] = m1_if.done;
  assign err[0] = m0_if.err;     assign err[1] = m1_if.err;
  assign rdata[0] = m0_if.rdata; assign rdata[1] = m1_if.rdata;

  dm_arbiter #(.RR_EN(1'b1), .DM_WORDS(2048)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .m0      (m0_if),
    .m1      (m1_if),
    .dm_ctrl (dm_ctrl),
    .dm_addr (dm_addr),
    .dm_wd   (dm_wd),
    .dm_rd   (dm_rd)
  );

  // Behavioural DM: combinational sign/zero-extending read, synchronous byte-lane write.
  logic [31:0] mem [0:2047];
  logic [31:0] m_word;
  logic [7:0]  m_byte;
  logic [15:0] m_half;
  always_comb begin
    m_word = mem[dm_addr[12:2]];
    m_byte = m_word[8*dm_addr[1:0] +: 8];
    m_half = dm_addr[1] ? m_word[31:16] : m_word[15:0];
    case (dm_ctrl)
      3'b000:  dm_rd = {{24{m_byte[7]}}, m_byte};
      3'b001:  dm_rd = {24'h0, m_byte};
      3'b010:  dm_rd = {{16{m_half[15]}}, m_half};
      3'b011:  dm_rd = {16'h0, m_half};
      default: dm_rd = m_word;
    endcase
  end
  always @(posedge clk) begin
    case (dm_ctrl)
      3'b101: mem[dm_addr[12:2]][8*dm_addr[1:0] +: 8] <= dm_wd[7:0];
      3'b110: mem[dm_addr[12:2]][16*dm_addr[1] +: 16] <= dm_wd[15:0];
      3'b111: mem[dm_addr[12:2]] <= dm_wd;
      default: ;
    endcase
  end

  int cyc = 0;
  int st_cnt = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (dm_ctrl == 3'b101 || dm_ctrl == 3'b110 || dm_ctrl == 3'b111) st_cnt <= st_cnt + 1;

  int n_cmp = 0;
  int n_fail = 0;
  logic [31:0] last_rd [2];
  logic [32:0] exp_q0 [$];
  logic [32:0] exp_q1 [$];
  int          own_q  [$];

  task automatic do_req(input int m, input logic [2:0] c, input logic [31:0] a, input logic [31:0] wd,
                        input logic lk, input logic [31:0] exp_rd, input logic exp_err,
                        output int gcyc, output int lat);
    logic [32:0] e;
    int n;
    @(posedge clk); #1;
    req[m] = 1'b1; ctrl[m] = c; addr[m] = a; wdata[m] = wd; lock[m] = lk;
    if (m == 0) exp_q0.push_back({exp_err, exp_rd}); else exp_q1.push_back({exp_err, exp_rd});
    n = 0;
    while (gnt[m] !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    gcyc = cyc; lat = n;
    n_cmp++;
    if (gnt[m] !== 1'b1) begin
      n_fail++;
      $display("FAIL gnt_timeout m%0d: gnt=%b after %0d cycles, required 1", m, gnt[m], n);
      req[m] = 1'b0;
      if (m == 0) void'(exp_q0.pop_front()); else void'(exp_q1.pop_front());
      return;
    end
    n_cmp++;
    if (dm_ctrl !== (exp_err ? DM_IDLE_CTRL : c)) begin
      n_fail++; $display("FAIL dm_ctrl_access m%0d: got %b required %b", m, dm_ctrl, exp_err ? DM_IDLE_CTRL : c);
    end
    req[m] = 1'b0; lock[m] = 1'b0;
    @(posedge clk); #1;
    e = (m == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
    n_cmp++;
    if (done[m] !== 1'b1) begin n_fail++; $display("FAIL done m%0d: got %b required 1", m, done[m]); end
    n_cmp++;
    if (err[m] !== e[32]) begin n_fail++; $display("FAIL err m%0d: got %b required %b", m, err[m], e[32]); end
    n_cmp++;
    if (rdata[m] !== e[31:0]) begin n_fail++; $display("FAIL rdata m%0d: got %h required %h", m, rdata[m], e[31:0]); end
    last_rd[m] = e[31:0];
  endtask

  task automatic test_reset;
    #3;
    n_cmp++;
    if ({gnt[0], gnt[1], done[0], done[1], err[0], err[1]} !== 6'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b required 000000", {gnt[0], gnt[1], done[0], done[1], err[0], err[1]});
    end
    n_cmp++;
    if (rdata[0] !== 32'h0 || rdata[1] !== 32'h0) begin
      n_fail++; $display("FAIL reset_rdata: got %h/%h required 0/0", rdata[0], rdata[1]);
    end
    n_cmp++;
    if ({dm_ctrl, dm_addr, dm_wd} !== 67'h0) begin
      n_fail++; $display("FAIL reset_dm: got ctrl=%b addr=%h wd=%h required all 0", dm_ctrl, dm_addr, dm_wd);
    end
    @(posedge clk); #2; rst_n = 1'b1;
  endtask

  task automatic test_store_load;
    int g, l, s0;
    s0 = st_cnt;
    do_req(0, DM_SW, 32'h10, 32'hDEADBEEF, 1'b0, last_rd[0], 1'b0, g, l);
    n_cmp++;
    if (l != 1) begin n_fail++; $display("FAIL sw_latency: got %0d required 1", l); end
    n_cmp++;
    if (dm_ctrl !== DM_IDLE_CTRL) begin n_fail++; $display("FAIL sw_ctrl_after: got %b required 000", dm_ctrl); end
    n_cmp++;
    if (st_cnt - s0 != 1) begin n_fail++; $display("FAIL sw_one_cycle: got %0d store cycles required 1", st_cnt - s0); end
    do_req(0, DM_LW, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0, g, l);
    n_cmp++;
    if (l != 1) begin n_fail++; $display("FAIL lw_latency: got %0d required 1", l); end
  endtask

  task automatic test_byte_loads;
    int g, l;
    do_req(1, DM_LB,  32'h10, 32'h0, 1'b0, 32'hFFFFFFEF, 1'b0, g, l);
    do_req(1, DM_LBU, 32'h10, 32'h0, 1'b0, 32'h000000EF, 1'b0, g, l);
  endtask

  task automatic test_errors;
    int g, l, s0;
    do_req(0, DM_LH, 32'h13, 32'h0, 1'b0, last_rd[0], 1'b1, g, l);
    s0 = st_cnt;
    do_req(0, DM_SW, 32'h12, 32'h0BADF00D, 1'b0, last_rd[0], 1'b1, g, l);
    n_cmp++;
    if (st_cnt != s0) begin n_fail++; $display("FAIL misaligned_sw_store: got %0d store cycles required 0", st_cnt - s0); end
    do_req(1, DM_SW, 32'h1FFC, 32'hCAFEF00D, 1'b0, last_rd[1], 1'b0, g, l);
    do_req(1, DM_LW, 32'h1FFC, 32'h0, 1'b0, 32'hCAFEF00D, 1'b0, g, l);
    do_req(1, DM_LW, 32'h2000, 32'h0, 1'b0, last_rd[1], 1'b1, g, l);
  endtask

  task automatic test_back_to_back;
    int got, n, ex;
    logic [1:0] gv;
    own_q.delete();
    for (int i = 0; i < 8; i++) own_q.push_back(i % 2);
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin req[k] = 1'b1; ctrl[k] = DM_LW; addr[k] = 32'h10; wdata[k] = 32'h0; lock[k] = 1'b0; end
    got = 0; n = 0;
    while (got < 8 && n < 40) begin
      @(posedge clk); #1; n++;
      gv = {gnt[1], gnt[0]};
      if (got > 0 || gv != 2'b00) begin
        n_cmp++;
        if ($countones(gv) != 1) begin n_fail++; $display("FAIL rr_one_access: cycle %0d gnt=%b required one-hot", cyc, gv); end
      end
      if (gv != 2'b00) begin
        ex = own_q.pop_front();
        n_cmp++;
        if (gv !== (2'b01 << ex)) begin n_fail++; $display("FAIL rr_order: grant %0d got %b required %b", got, gv, 2'b01 << ex); end
        got++;
      end
      for (int k = 0; k < 2; k++) if (done[k] === 1'b1) begin
        n_cmp++;
        if (rdata[k] !== 32'hDEADBEEF || err[k] !== 1'b0) begin
          n_fail++; $display("FAIL rr_rdata m%0d: got %h err=%b required DEADBEEF err=0", k, rdata[k], err[k]);
        end
      end
    end
    req[0] = 1'b0; req[1] = 1'b0;
    n_cmp++;
    if (got != 8) begin n_fail++; $display("FAIL rr_timeout: got %0d grants required 8", got); end
    repeat (3) @(posedge clk);
    #1;
    last_rd[0] = 32'hDEADBEEF; last_rd[1] = 32'hDEADBEEF;
  endtask

  task automatic test_reset_mid_access;
    int n;
    logic seen;
    @(posedge clk); #1;
    req[0] = 1'b1; ctrl[0] = DM_SW; addr[0] = 32'h20; wdata[0] = 32'h12345678; lock[0] = 1'b0;
    n = 0;
    while (gnt[0] !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    n_cmp++;
    if (dm_ctrl !== DM_SW) begin n_fail++; $display("FAIL rst_pre_ctrl: got %b required 111", dm_ctrl); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (dm_ctrl !== DM_IDLE_CTRL) begin n_fail++; $display("FAIL rst_async_ctrl: got %b required 000", dm_ctrl); end
    n_cmp++;
    if ({gnt[0], gnt[1], done[0], done[1]} !== 4'b0) begin
      n_fail++; $display("FAIL rst_async_flags: got %b required 0000", {gnt[0], gnt[1], done[0], done[1]});
    end
    n_cmp++;
    if (rdata[0] !== 32'h0) begin n_fail++; $display("FAIL rst_async_rdata: got %h required 0", rdata[0]); end
    req[0] = 1'b0;
    @(posedge clk); #2; rst_n = 1'b1;
    seen = 1'b0;
    repeat (4) begin @(posedge clk); #1; if (done[0] === 1'b1 || done[1] === 1'b1) seen = 1'b1; end
    n_cmp++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL rst_no_done: got done after release, required none"); end
    last_rd[0] = 32'h0; last_rd[1] = 32'h0;
  endtask

`ifdef DM_ARB_LOCK_EN
  task automatic test_lock;
    int ga, gb, g1, l;
    fork
      begin
        do_req(0, DM_LW, 32'h10, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0, ga, l);
        do_req(0, DM_SW, 32'h30, 32'h55AA55AA, 1'b0, 32'hDEADBEEF, 1'b0, gb, l);
      end
      do_req(1, DM_LW, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0, g1, l);
    join
    n_cmp++;
    if (!(g1 > gb && gb > ga)) begin
      n_fail++; $display("FAIL lock_order: m0 LW gnt %0d, m0 SW gnt %0d, m1 gnt %0d; required m1 after SW", ga, gb, g1);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 32'h0;
    for (int k = 0; k < 2; k++) begin
      req[k] = 1'b0; ctrl[k] = 3'b000; addr[k] = 32'h0; wdata[k] = 32'h0; lock[k] = 1'b0; last_rd[k] = 32'h0;
    end
    test_reset();
    test_store_load();
    test_byte_loads();
    test_errors();
    test_back_to_back();
    test_reset_mid_access();
`ifdef DM_ARB_LOCK_EN
    test_lock();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Two-master arbiter and sequencer in front of the single-ported 8 KB data memory (2048 x 32, word index = addr[12:2], 3-bit DM control code).
- Master 0 is the CPU MEM stage; master 1 is the debug/DMA port.
- Handles request/grant, round-robin fairness, and alignment/range checking, and guarantees the DM sees a store code for exactly one cycle per granted store.

Parameters:
- RR_EN, 1, 1 = round-robin between masters; 0 = fixed priority, master 0 wins.
- DM_WORDS, 2048, DM depth in words; byte addresses at or above DM_WORDS*4 are out of range.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- m0_req / m1_req  in  1  request; held with command stable until gnt seen
- m0_ctrl / m1_ctrl  in  3  DM op code: 000 LB, 001 LBU, 010 LH, 011 LHU, 100 LW, 101 SB, 110 SH, 111 SW
- m0_addr / m1_addr  in  32  byte address
- m0_wdata / m1_wdata  in  32  store data
- m0_gnt / m1_gnt  out  1  registered one-cycle grant pulse
- m0_done / m1_done  out  1  registered one-cycle completion pulse
- m0_err / m1_err  out  1  valid with done; misaligned or out-of-range
- m0_rdata / m1_rdata  out  32  load result, valid with done, held until next done
- dm_ctrl  out  3  to DM control input
- dm_addr  out  32  to DM address
- dm_wd  out  32  to DM write data
- dm_rd  in  32  DM combinational read data

Behaviour:
- Reset (async, rst_n=0):
  - All gnt/done/err = 0; rdata = 0; state IDLE; priority pointer -> master 0.
  - dm_ctrl = 000, dm_addr = 0, dm_wd = 0. 000 (LB) is the idle code and has no side effect.
  - Reset asserted mid-access aborts the access; a store whose ACCESS cycle was cut by reset may or may not have written.
- States:
  - IDLE: no access this cycle; DM driven with the idle code.
  - ACCESS: captured command driven to the DM for exactly one cycle.
- Cycle T, arbiter free: a master's req is high. At the end of T the winner's ctrl/addr/wdata are captured and the state goes to ACCESS.
- Cycle T+1 (ACCESS):
  - Winner's gnt = 1.
  - dm_ctrl/dm_addr/dm_wd come from the capture registers only, never combinationally from master inputs.
  - Error check in this cycle, per captured access:
    - Misaligned: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=00.
    - Out of range: addr >= DM_WORDS*4.
    - Either case -> DM driven with the idle code; the error is recorded.
  - Load: dm_rd is registered into the winner's rdata at the end of T+1.
- Cycle T+2: winner's done = 1; err = recorded error. A store, or any errored access, leaves rdata unchanged.
- Mask rule: during the cycle a master's gnt is high, its req is ignored (the requester drops req in response to gnt).
- Back-to-back: in ACCESS the other master's req may be captured, so ACCESS->ACCESS. Peak rate is 1 access/cycle alternating; the same master gets at most 1 access per 2 cycles.
- With no captured request, ACCESS->IDLE.
- Arbitration with both requesting, RR_EN=1:
  - Grant goes to the pointer master; the pointer then moves to the other master.
  - A single requester is granted regardless of the pointer; the pointer moves past it.
- RR_EN=0: master 0 always wins; master 1 can starve (documented).
- Stores: dm_ctrl carries 101/110/111 in the ACCESS cycle only; it returns to 000 in the next IDLE cycle or carries the next command.
- Loads never write. The DM sign/zero-extends; the arbiter passes dm_rd through unmodified.

Optional Feature:
- Macro DM_ARB_LOCK_EN.
- Defined:
  - Adds inputs m0_lock / m1_lock (1 bit, sampled with req).
  - A grant with lock=1 sets the owner; the other master is not granted until the owner completes a granted access with lock=0 (read-modify-write atomicity).
  - The owner's back-to-back spacing stays 2 cycles.
  - The round-robin pointer is frozen while locked.
- Undefined: no lock ports; arbitration exactly as above.

Decomposition:
- Package dm_arb_pkg:
  - DM op code constants (LB..SW), DM_IDLE_CTRL = 000.
  - State enum {IDLE, ACCESS}.
  - Helper function is_store(ctrl).
- One natural sub-module: dm_arb_chk, purely combinational. Inputs ctrl and addr; outputs misaligned, out_of_range, and ctrl_to_dm (idle code on error).

Test Plan:
- m0 SW addr 0x10 wdata 0xDEADBEEF, then LW 0x10 -> m0_gnt at T+1, done at T+2 both times; second rdata 0xDEADBEEF; dm_ctrl=111 for exactly 1 cycle.
- After the store above, m1 LB 0x10 and LBU 0x10 -> rdata 0xFFFFFFEF and 0x000000EF.
- m0 and m1 hold req continuously with LW, RR_EN=1 -> grants alternate m0,m1,m0,...; one ACCESS every cycle; no master granted twice in a row.
- m0 LH addr 0x13 -> done with err=1; dm_ctrl stays 000 throughout; rdata unchanged. m1 LW addr 0x2000 -> err=1.
- rst_n pulsed low during the ACCESS cycle of an SW -> dm_ctrl goes 000 asynchronously; gnt/done low; no done after release.
- DM_ARB_LOCK_EN: m0 LW lock=1 then SW lock=0, m1 requesting throughout -> m1 granted only after m0's SW grant.
